rv32im_dmem: RTL and testbench
==============================

Name: rv32im_dmem

Overview:
- Data-memory responder on the far end of the EXU load/store interface. It consumes `val_memaddr`, `val_memdatawr` and the LSU opcode from rv32im_exu, and returns `val_memdatard` to it.
- Performs byte, halfword and word accesses on an internal word-organised RAM.
- Handles little-endian lane steering and sign/zero extension, and flags misaligned or out-of-range accesses.
- Uses a valid/ready request handshake and a single-cycle response pulse.

Parameters:
- DEPTH, 1024, number of 32-bit words in the RAM.
- BASE_ADDR, 32'h0000_0000, byte address of word 0. Accesses are relative to it.

Ports:
- clk_i  input  1  core clock; all state changes on the rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  block can accept a request.
- lsu_opcode_i  input  `LSU_OPCODE_WIDTH  LSU operation (`LSU_OPCODE_*`).
- val_memaddr_i  input  `API_DATA_WIDTH  byte address.
- val_memdatawr_i  input  `API_DATA_WIDTH  store data, right-aligned.
- rsp_valid_o  output  1  one-cycle response strobe.
- val_memdatard_o  output  `API_DATA_WIDTH  load result, already extended.
- err_o  output  1  access fault, qualified by rsp_valid_o.

Behaviour:
- Reset (async, active-low):
  - State goes to IDLE; req_ready_o=1, rsp_valid_o=0, val_memdatard_o=0, err_o=0.
  - RAM contents are not reset.
- State machine IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - req_ready_o=1.
  - On a rising edge with req_valid_i=1 and opcode != `LSU_OPCODE_NONE`: latch opcode, offset (addr - BASE_ADDR) and wdata, then go to ACCESS.
  - An `LSU_OPCODE_NONE` request is accepted and discarded; it produces no response.
- ACCESS (1 cycle):
  - req_ready_o=0.
  - Compute fault. fault = misaligned OR (offset[31:2] >= DEPTH).
  - Misaligned means: H/HU/SH with offset[0]=1, or W/SW with offset[1:0] != 0.
  - Store without fault: write the enabled lanes at this edge.
    - SB: lane offset[1:0] <- wdata[7:0].
    - SH: lanes {offset[1],0..1} <- wdata[15:0].
    - SW: all lanes.
    - Other lanes are unchanged.
  - Load without fault: the RAM word is registered at this edge.
  - Next state is RESP.
- RESP:
  - req_ready_o=0, rsp_valid_o=1 for exactly one cycle, err_o=fault.
  - Load result:
    - LB: sign-extend the selected byte.
    - LBU: zero-extend the selected byte.
    - LH: sign-extend the selected half.
    - LHU: zero-extend the selected half.
    - LW: the whole word.
  - Stores and faults return val_memdatard_o=0.
  - Next state is IDLE. Outputs return to 0 except req_ready_o=1.
- Latency and throughput:
  - Request accepted at edge N gives rsp_valid_o high in cycle N+2.
  - Maximum throughput is one request per 3 cycles. Back-to-back requests are accepted only in IDLE.
- Faulting stores never modify the RAM.
- Read-after-write of the same address in consecutive requests returns the new data.
- Inputs are sampled only at the accept edge. Changes afterwards have no effect.
- Offset arithmetic is 32-bit modulo. Addresses below BASE_ADDR wrap high and fault as out-of-range.
- Reset mid-operation: the RAM write enable is gated by state==ACCESS and rst_ni. A reset asserted before the ACCESS edge drops the pending store. No response is issued for an aborted request.

Decomposition:
- The `LSU_OPCODE_*`, `LSU_OPCODE_WIDTH` and `API_DATA_WIDTH` defines stay in the shared core defines header. Add state encodings `DMEM_ST_IDLE`/`ACCESS`/`RESP` (2 bits) there.
- One sub-module: rv32im_dmem_ram.
  - Contents: DEPTH x 32 synchronous RAM with 4 byte-write enables and a registered read port.
  - The FSM, lane steering and extension stay in rv32im_dmem.

Test Plan:
1. SW 0x10 <- 0xDEADBEEF, then LW 0x10 -> rsp_valid_o 2 cycles after accept, data 0xDEADBEEF, err_o=0; req_ready_o low for exactly 2 cycles after each accept.
2. SB 0x11 <- 0x00000080, then LB 0x11 -> 0xFFFFFF80; LBU 0x11 -> 0x00000080; LW 0x10 -> 0xDEAD80EF.
3. SH 0x12 <- 0x0000F234, then LH 0x12 -> 0xFFFFF234; LHU 0x12 -> 0x0000F234; LW 0x10 -> 0xF23480EF.
4. LW 0x13 -> err_o=1, data 0. SH 0x11 <- 0xFFFF -> err_o=1, then LW 0x10 still 0xF23480EF. Access at 4*DEPTH -> err_o=1.
5. req_valid_i=1 with `LSU_OPCODE_NONE` -> no rsp_valid_o within 5 cycles, req_ready_o stays 1.
6. Issue SW 0x20 <- 0x55; assert rst_ni=0 during ACCESS before the edge -> outputs take reset values immediately, no rsp_valid_o. After release, LW 0x20 returns the prior value (0 if preloaded 0).

Source files
------------

// File: rtl/rv32im_dmem_pkg.sv
// -----------------------------------------------------------------------------
// rv32im_dmem_pkg
// Shared definitions for the data-memory responder:
//   - bus widths (API_DATA_WIDTH, LSU_OPCODE_WIDTH)
//   - LSU opcode encoding (LSU_OPCODE_*)
//   - responder FSM state encoding (DMEM_ST_*)
//   - opcode classification and alignment helpers
// -----------------------------------------------------------------------------
package rv32im_dmem_pkg;

   localparam int API_DATA_WIDTH   = 32;
   localparam int LSU_OPCODE_WIDTH = 4;

   typedef enum logic [LSU_OPCODE_WIDTH-1:0] {
      LSU_OPCODE_NONE = 4'd0,
      LSU_OPCODE_LB   = 4'd1,
      LSU_OPCODE_LBU  = 4'd2,
      LSU_OPCODE_LH   = 4'd3,
      LSU_OPCODE_LHU  = 4'd4,
      LSU_OPCODE_LW   = 4'd5,
      LSU_OPCODE_SB   = 4'd6,
      LSU_OPCODE_SH   = 4'd7,
      LSU_OPCODE_SW   = 4'd8
   } lsu_opcode_e;

   typedef enum logic [1:0] {
      DMEM_ST_IDLE   = 2'd0,
      DMEM_ST_ACCESS = 2'd1,
      DMEM_ST_RESP   = 2'd2
   } dmem_state_e;

   function automatic logic is_store(input lsu_opcode_e op);
      return (op == LSU_OPCODE_SB) || (op == LSU_OPCODE_SH) || (op == LSU_OPCODE_SW);
   endfunction

   function automatic logic is_load(input lsu_opcode_e op);
      return (op == LSU_OPCODE_LB) || (op == LSU_OPCODE_LBU) || (op == LSU_OPCODE_LH) ||
             (op == LSU_OPCODE_LHU) || (op == LSU_OPCODE_LW);
   endfunction

   // Halfwords need an even offset, words a multiple of four; bytes never fault here.
   function automatic logic misaligned(input lsu_opcode_e op, input logic [1:0] off);
      case (op)
         LSU_OPCODE_LH, LSU_OPCODE_LHU, LSU_OPCODE_SH: return off[0];
         LSU_OPCODE_LW, LSU_OPCODE_SW:                 return |off;
         default:                                      return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/rv32im_dmem_if.sv
// -----------------------------------------------------------------------------
// rv32im_dmem_if
// Load/store request/response bundle between the EXU (master) and the data
// memory (slave).
//   req_valid     : request present                 (master -> slave)
//   req_ready     : slave can accept a request      (slave  -> master)
//   lsu_opcode    : LSU operation                   (master -> slave)
//   val_memaddr   : byte address                    (master -> slave)
//   val_memdatawr : store data, right-aligned       (master -> slave)
//   rsp_valid     : one-cycle response strobe       (slave  -> master)
//   val_memdatard : load result, already extended   (slave  -> master)
//   err           : access fault, with rsp_valid    (slave  -> master)
// -----------------------------------------------------------------------------
interface rv32im_dmem_if;
   import rv32im_dmem_pkg::*;

   logic                      req_valid;
   logic                      req_ready;
   lsu_opcode_e               lsu_opcode;
   logic [API_DATA_WIDTH-1:0] val_memaddr;
   logic [API_DATA_WIDTH-1:0] val_memdatawr;
   logic                      rsp_valid;
   logic [API_DATA_WIDTH-1:0] val_memdatard;
   logic                      err;

   modport master (
      output req_valid, lsu_opcode, val_memaddr, val_memdatawr,
      input  req_ready, rsp_valid, val_memdatard, err
   );

   modport slave (
      input  req_valid, lsu_opcode, val_memaddr, val_memdatawr,
      output req_ready, rsp_valid, val_memdatard, err
   );

endinterface

// File: rtl/rv32im_dmem_ram.sv
// -----------------------------------------------------------------------------
// rv32im_dmem_ram
// DEPTH x 32 synchronous RAM with per-byte write enables and a registered read
// port.
//   clk_i   : clock
//   i_we    : write strobe, i_be selects the written lanes
//   i_be    : byte enables, bit n covers i_wdata[8n+7:8n]
//   i_addr  : word index
//   i_wdata : write data, already lane-steered
//   i_re    : read strobe, o_rdata updates on the next edge
//   o_rdata : registered read data
// -----------------------------------------------------------------------------
module rv32im_dmem_ram #(
   parameter int DEPTH = 1024,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk_i,
   input  logic          i_we,
   input  logic [3:0]    i_be,
   input  logic [AW-1:0] i_addr,
   input  logic [31:0]   i_wdata,
   input  logic          i_re,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [DEPTH];
   logic [31:0] r_rdata;

   // NOTE: the array has no reset so it maps onto block RAM; contents survive rst_ni.
   always_ff @(posedge clk_i) begin
      if (i_we) begin
         for (int lane = 0; lane < 4; lane++) begin
            if (i_be[lane]) r_mem[i_addr][8*lane +: 8] <= i_wdata[8*lane +: 8];
         end
      end
      if (i_re) r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/rv32im_dmem.sv
// -----------------------------------------------------------------------------
// rv32im_dmem
// Data-memory responder for the EXU load/store path. A request is accepted in
// IDLE, the RAM is accessed in ACCESS and a one-cycle response is returned in
// RESP. Handles little-endian lane steering, sign/zero extension and flags
// misaligned or out-of-range accesses (faulting stores leave the RAM intact).
//   clk_i  : core clock
//   rst_ni : asynchronous active-low reset
//   bus    : rv32im_dmem_if slave (request, response, error)
// -----------------------------------------------------------------------------
module rv32im_dmem
   import rv32im_dmem_pkg::*;
#(
   parameter int          DEPTH     = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   rv32im_dmem_if.slave  bus
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   dmem_state_e r_state;
   lsu_opcode_e r_opcode;
   logic [31:0] r_offset;
   logic [31:0] r_wdata;
   logic        r_req_ready;
   logic        r_rsp_valid;
   logic        r_err;

   logic          w_fault;
   logic          w_ram_we;
   logic          w_ram_re;
   logic [3:0]    w_ram_be;
   logic [31:0]   w_ram_wdata;
   logic [31:0]   w_ram_rdata;
   logic [AW-1:0] w_ram_addr;
   logic [7:0]    w_byte;
   logic [15:0]   w_half;
   logic [31:0]   w_load_data;

   // Offsets below BASE_ADDR wrap high and land in the out-of-range check.
   assign w_fault    = misaligned(r_opcode, r_offset[1:0]) || ((r_offset >> 2) >= 32'(DEPTH));
   assign w_ram_addr = r_offset[AW+1:2];

   // rst_ni in the enable drops a store whose ACCESS edge is overtaken by reset.
   assign w_ram_we = (r_state == DMEM_ST_ACCESS) && rst_ni && is_store(r_opcode) && !w_fault;
   assign w_ram_re = (r_state == DMEM_ST_ACCESS) && is_load(r_opcode) && !w_fault;

   // Store data is replicated across lanes; the byte enables pick the target.
   always_comb begin
      // NOTE: every output gets a default first so no latch is inferred.
      w_ram_be    = 4'b0000;
      w_ram_wdata = r_wdata;
      case (r_opcode)
         LSU_OPCODE_SB: begin
            w_ram_be    = 4'b0001 << r_offset[1:0];
            w_ram_wdata = {4{r_wdata[7:0]}};
         end
         LSU_OPCODE_SH: begin
            w_ram_be    = r_offset[1] ? 4'b1100 : 4'b0011;
            w_ram_wdata = {2{r_wdata[15:0]}};
         end
         LSU_OPCODE_SW: w_ram_be = 4'b1111;
         default: ;
      endcase
   end

   rv32im_dmem_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk_i   (clk_i),
      .i_we    (w_ram_we),
      .i_be    (w_ram_be),
      .i_addr  (w_ram_addr),
      .i_wdata (w_ram_wdata),
      .i_re    (w_ram_re),
      .o_rdata (w_ram_rdata)
   );

   // Load lane select and extension from the registered RAM word.
   assign w_byte = w_ram_rdata[{r_offset[1:0], 3'b000} +: 8];
   assign w_half = r_offset[1] ? w_ram_rdata[31:16] : w_ram_rdata[15:0];

   always_comb begin
      w_load_data = '0;
      case (r_opcode)
         LSU_OPCODE_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
         LSU_OPCODE_LBU: w_load_data = {24'h0, w_byte};
         LSU_OPCODE_LH:  w_load_data = {{16{w_half[15]}}, w_half};
         LSU_OPCODE_LHU: w_load_data = {16'h0, w_half};
         LSU_OPCODE_LW:  w_load_data = w_ram_rdata;
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= DMEM_ST_IDLE;
         r_opcode    <= LSU_OPCODE_NONE;
         r_offset    <= '0;
         r_wdata     <= '0;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         case (r_state)
            DMEM_ST_IDLE: begin
               // A NONE request is consumed here without a response.
               if (bus.req_valid && (bus.lsu_opcode != LSU_OPCODE_NONE)) begin
                  r_opcode    <= bus.lsu_opcode;
                  r_offset    <= bus.val_memaddr - BASE_ADDR;
                  r_wdata     <= bus.val_memdatawr;
                  r_req_ready <= 1'b0;
                  r_state     <= DMEM_ST_ACCESS;
               end
            end
            DMEM_ST_ACCESS: begin
               r_rsp_valid <= 1'b1;
               r_err       <= w_fault;
               r_state     <= DMEM_ST_RESP;
            end
            DMEM_ST_RESP: begin
               r_rsp_valid <= 1'b0;
               r_err       <= 1'b0;
               r_req_ready <= 1'b1;
               r_state     <= DMEM_ST_IDLE;
            end
            default: begin
               r_rsp_valid <= 1'b0;
               r_err       <= 1'b0;
               r_req_ready <= 1'b1;
               r_state     <= DMEM_ST_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready     = r_req_ready;
   assign bus.rsp_valid     = r_rsp_valid;
   assign bus.err           = r_err;
   assign bus.val_memdatard = (r_rsp_valid && !r_err) ? w_load_data : '0;

endmodule

// File: tb/tb_rv32im_dmem.sv
// -----------------------------------------------------------------------------
// tb_rv32im_dmem
// Directed vector bench for rv32im_dmem: a table of load/store requests with
// hand-computed results, plus sequences for NONE requests and reset during
// ACCESS.
// -----------------------------------------------------------------------------
module tb_rv32im_dmem;
   import rv32im_dmem_pkg::*;

   localparam int DEPTH = 1024;

   typedef struct {
      lsu_opcode_e op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_data;
      logic        exp_err;
      string       name;
   } vec_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   vec_t vecs[$];

   rv32im_dmem_if bus ();

   rv32im_dmem #(
      .DEPTH     (DEPTH),
      .BASE_ADDR (32'h0000_0000)
   ) u_dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void add(input lsu_opcode_e op, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_data,
                               input logic exp_err, input string name);
      vec_t v;
      v.op = op; v.addr = addr; v.wdata = wdata;
      v.exp_data = exp_data; v.exp_err = exp_err; v.name = name;
      vecs.push_back(v);
   endfunction

   // Issue one request in IDLE and check the full accept/access/response timing.
   task automatic do_req(input lsu_opcode_e op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_data,
                         input logic exp_err, input string name);
      int waited = 0;
      @(negedge clk);
      while (!bus.req_ready && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      check({name, " ready_before"}, 32'(bus.req_ready), 32'd1);
      bus.req_valid     = 1'b1;
      bus.lsu_opcode    = op;
      bus.val_memaddr   = addr;
      bus.val_memdatawr = wdata;
      @(posedge clk);
      #1;
      // Garbage after the accept edge must be ignored.
      bus.req_valid     = 1'b0;
      bus.lsu_opcode    = LSU_OPCODE_SW;
      bus.val_memaddr   = 32'h0000_0010;
      bus.val_memdatawr = 32'hA5A5_A5A5;
      check({name, " ready_c1"}, 32'(bus.req_ready), 32'd0);
      check({name, " rsp_c1"},   32'(bus.rsp_valid), 32'd0);
      @(posedge clk);
      #1;
      check({name, " ready_c2"}, 32'(bus.req_ready), 32'd0);
      check({name, " rsp_c2"},   32'(bus.rsp_valid), 32'd1);
      check({name, " err"},      32'(bus.err),       32'(exp_err));
      check({name, " data"},     bus.val_memdatard,  exp_data);
      @(posedge clk);
      #1;
      check({name, " ready_c3"}, 32'(bus.req_ready), 32'd1);
      check({name, " rsp_c3"},   32'(bus.rsp_valid), 32'd0);
      check({name, " data_c3"},  bus.val_memdatard,  32'h0);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.req_valid     = 1'b0;
      bus.lsu_opcode    = LSU_OPCODE_NONE;
      bus.val_memaddr   = '0;
      bus.val_memdatawr = '0;

      // Word, byte and halfword traffic, extension and lane merging.
      add(LSU_OPCODE_SW,  32'h10, 32'hDEAD_BEEF, 32'h0,          1'b0, "sw_10");
      add(LSU_OPCODE_LW,  32'h10, 32'h0,         32'hDEAD_BEEF,  1'b0, "lw_10_a");
      add(LSU_OPCODE_SB,  32'h11, 32'h0000_0080, 32'h0,          1'b0, "sb_11");
      add(LSU_OPCODE_LB,  32'h11, 32'h0,         32'hFFFF_FF80,  1'b0, "lb_11");
      add(LSU_OPCODE_LBU, 32'h11, 32'h0,         32'h0000_0080,  1'b0, "lbu_11");
      add(LSU_OPCODE_LW,  32'h10, 32'h0,         32'hDEAD_80EF,  1'b0, "lw_10_b");
      add(LSU_OPCODE_SH,  32'h12, 32'h0000_F234, 32'h0,          1'b0, "sh_12");
      add(LSU_OPCODE_LH,  32'h12, 32'h0,         32'hFFFF_F234,  1'b0, "lh_12");
      add(LSU_OPCODE_LHU, 32'h12, 32'h0,         32'h0000_F234,  1'b0, "lhu_12");
      add(LSU_OPCODE_LW,  32'h10, 32'h0,         32'hF234_80EF,  1'b0, "lw_10_c");
      add(LSU_OPCODE_LB,  32'h13, 32'h0,         32'hFFFF_FFF2,  1'b0, "lb_13");
      add(LSU_OPCODE_LH,  32'h10, 32'h0,         32'hFFFF_80EF,  1'b0, "lh_10");
      add(LSU_OPCODE_LHU, 32'h10, 32'h0,         32'h0000_80EF,  1'b0, "lhu_10");
      // Faults: misalignment, out of range, wrapped address, faulting store.
      add(LSU_OPCODE_LW,  32'h13, 32'h0,         32'h0,          1'b1, "lw_13_mis");
      add(LSU_OPCODE_SH,  32'h11, 32'h0000_FFFF, 32'h0,          1'b1, "sh_11_mis");
      add(LSU_OPCODE_LW,  32'h10, 32'h0,         32'hF234_80EF,  1'b0, "lw_10_d");
      add(LSU_OPCODE_LW,  32'(4*DEPTH), 32'h0,   32'h0,          1'b1, "lw_oor");
      add(LSU_OPCODE_SW,  32'(4*DEPTH), 32'h1,   32'h0,          1'b1, "sw_oor");
      add(LSU_OPCODE_LW,  32'hFFFF_FFFC, 32'h0,  32'h0,          1'b1, "lw_wrap");
      // Last valid word and byte store with junk in the upper bits.
      add(LSU_OPCODE_SW,  32'(4*DEPTH-4), 32'h1234_5678, 32'h0,  1'b0, "sw_last");
      add(LSU_OPCODE_LW,  32'(4*DEPTH-4), 32'h0, 32'h1234_5678,  1'b0, "lw_last");
      add(LSU_OPCODE_SW,  32'h14, 32'h0,         32'h0,          1'b0, "sw_14");
      add(LSU_OPCODE_SB,  32'h14, 32'hAABB_CC7F, 32'h0,          1'b0, "sb_14");
      add(LSU_OPCODE_LW,  32'h14, 32'h0,         32'h0000_007F,  1'b0, "lw_14");

      repeat (3) @(posedge clk);
      #1;
      check("reset ready", 32'(bus.req_ready), 32'd1);
      check("reset rsp",   32'(bus.rsp_valid), 32'd0);
      check("reset err",   32'(bus.err),       32'd0);
      check("reset data",  bus.val_memdatard,  32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         do_req(vecs[i].op, vecs[i].addr, vecs[i].wdata,
                vecs[i].exp_data, vecs[i].exp_err, vecs[i].name);
      end

      // NONE request: consumed silently, ready never drops.
      @(negedge clk);
      bus.req_valid   = 1'b1;
      bus.lsu_opcode  = LSU_OPCODE_NONE;
      bus.val_memaddr = 32'h10;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         check($sformatf("none rsp c%0d", c),   32'(bus.rsp_valid), 32'd0);
         check($sformatf("none ready c%0d", c), 32'(bus.req_ready), 32'd1);
      end
      bus.req_valid = 1'b0;

      // Reset during ACCESS drops the pending store and its response.
      do_req(LSU_OPCODE_SW, 32'h20, 32'h1111_1111, 32'h0, 1'b0, "sw_20_pre");
      @(negedge clk);
      bus.req_valid     = 1'b1;
      bus.lsu_opcode    = LSU_OPCODE_SW;
      bus.val_memaddr   = 32'h20;
      bus.val_memdatawr = 32'h0000_0055;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      check("abort in_access ready", 32'(bus.req_ready), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort ready", 32'(bus.req_ready), 32'd1);
      check("abort rsp",   32'(bus.rsp_valid), 32'd0);
      check("abort err",   32'(bus.err),       32'd0);
      check("abort data",  bus.val_memdatard,  32'h0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         check($sformatf("abort no_rsp c%0d", c), 32'(bus.rsp_valid), 32'd0);
      end
      do_req(LSU_OPCODE_LW, 32'h20, 32'h0, 32'h1111_1111, 1'b0, "lw_20_post");
      do_req(LSU_OPCODE_LW, 32'h10, 32'h0, 32'hF234_80EF, 1'b0, "lw_10_post");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
